// File: rtl/servo_cmd_rx.sv
// servo_cmd_rx: 8N1 UART command receiver for the remote servo path.
// Parses A5/POS/CHK frames and turns POS into a PWM duty value.
module servo_cmd_rx #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter int unsigned DUTY_MIN       = 25_000,
  parameter int unsigned DUTY_MAX       = 50_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] duty_cycle,
  output logic        duty_valid,
  output logic [7:0]  last_pos,
  output logic        frame_err
);

  localparam int unsigned CPB = CLK_FREQ / BAUD;
  localparam int unsigned CW  = $clog2(CPB);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [39:0]   SPAN     = 40'(DUTY_MAX - DUTY_MIN);
  localparam logic [7:0]    HDR      = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_HDR, P_POS, P_CHK
  } p_state_t;

  logic          rst_i;
  logic [1:0]    rst_q;
  logic          rx_meta;
  logic          rxs;
  rx_state_t     rx_state;
  rx_state_t     rx_next;
  p_state_t      p_state;
  p_state_t      p_next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    pos_q;
  logic [TW-1:0] tcnt;
  logic          half_end;
  logic          bit_end;
  logic          byte_stb;
  logic          stop_err;
  logic          accept;
  logic          chk_err;
  logic          t_en;
  logic          timeout;
  logic [39:0]   prod;
  logic [39:0]   sum;
  logic [31:0]   duty_calc;

  // Reset: asserts asynchronously, releases on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_i = rst_q[1];

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign half_end = (cnt == HALF_END);
  assign bit_end  = (cnt == BIT_END);

  // Receiver state register
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next state, byte strobe and stop-bit error
  always_comb begin
    rx_next  = rx_state;
    byte_stb = 1'b0;
    stop_err = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (!rxs) rx_next = RX_START;
      RX_START: if (half_end) rx_next = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (bit_end) begin
          rx_next  = RX_IDLE;
          byte_stb = rxs;
          stop_err = !rxs;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (rx_state != rx_next || (rx_state == RX_DATA && bit_end))
        cnt <= '0;
      else if (rx_state != RX_IDLE)
        cnt <= cnt + 1'b1;
      if (rx_state == RX_START)
        bit_idx <= 3'd0;
      if (rx_state == RX_DATA && bit_end) begin
        shreg   <= {rxs, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign t_en    = (p_state != P_HDR) && (rx_state == RX_IDLE);
  assign timeout = t_en && (tcnt == TO_END);

  // Inter-byte idle counter, only live mid-frame
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i)                         tcnt <= '0;
    else if (byte_stb || p_state == P_HDR) tcnt <= '0;
    else if (t_en)                      tcnt <= tcnt + 1'b1;
  end

  // Parser state register and stored position
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      p_state <= P_HDR;
      pos_q   <= 8'h00;
    end else begin
      p_state <= p_next;
      if (byte_stb && p_state == P_POS) pos_q <= shreg;
    end
  end

  // Parser next state and frame verdict
  always_comb begin
    p_next  = p_state;
    accept  = 1'b0;
    chk_err = 1'b0;
    if (stop_err || timeout) begin
      p_next = P_HDR;
    end else if (byte_stb) begin
      unique case (p_state)
        P_HDR: if (shreg == HDR) p_next = P_POS;
        P_POS: p_next = P_CHK;
        P_CHK: begin
          p_next  = P_HDR;
          accept  = (shreg == (HDR ^ pos_q));
          chk_err = (shreg != (HDR ^ pos_q));
        end
        default: p_next = P_HDR;
      endcase
    end
  end

  // Position to duty scaling, 255 pinned to the top of the range
  always_comb begin
    prod      = 40'(pos_q) * SPAN;
    sum       = 40'(DUTY_MIN) + (prod >> 8);
    duty_calc = (pos_q == 8'hFF) ? 32'(DUTY_MAX) : sum[31:0];
  end

  // Output registers: duty held until the next accepted frame
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      duty_cycle <= 32'(DUTY_MIN);
      last_pos   <= 8'h00;
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      duty_valid <= accept;
      frame_err  <= stop_err | chk_err | timeout;
      if (accept) begin
        duty_cycle <= duty_calc;
        last_pos   <= pos_q;
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_rx.sv
// tb_servo_cmd_rx: directed table-driven bench for servo_cmd_rx.
// Bit period is 10 clocks; duty range 1000..2000.
module tb_servo_cmd_rx;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [31:0] duty_cycle;
  logic        duty_valid;
  logic [7:0]  last_pos;
  logic        frame_err;

  int checks;
  int errors;
  int dv_cnt;
  int fe_cnt;
  int cyc;
  int dv_cyc;
  int last_start;

  servo_cmd_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD(100_000),
    .DUTY_MIN(1000),
    .DUTY_MAX(2000),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .duty_cycle(duty_cycle),
    .duty_valid(duty_valid),
    .last_pos(last_pos),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         duty;
    logic [7:0] pos;
    int         dv;
    int         fe;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (duty_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (duty_valid || frame_err)
      check("excl", 64'(duty_valid && frame_err), 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stp);
    last_start = cyc;
    rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) tick();
    end
    rx = stp;
    repeat (10) tick();
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  initial begin
    int dv0;
    int fe0;
    logic [7:0] pb;
    checks = 0; errors = 0; dv_cnt = 0; fe_cnt = 0;
    cyc = 0; dv_cyc = 0; last_start = 0;

    vecs[0] = '{8'hA5, 8'h80, 8'h25, 1500, 8'h80, 1, 0};
    vecs[1] = '{8'hA5, 8'hFF, 8'h5A, 2000, 8'hFF, 1, 0};
    vecs[2] = '{8'hA5, 8'h00, 8'hA5, 1000, 8'h00, 1, 0};
    vecs[3] = '{8'hA5, 8'h40, 8'h00, 1000, 8'h00, 0, 1};
    vecs[4] = '{8'hA5, 8'h40, 8'hE5, 1250, 8'h40, 1, 0};
    vecs[5] = '{8'hA5, 8'hA5, 8'h00, 1644, 8'hA5, 1, 0};
    vecs[6] = '{8'hA5, 8'h01, 8'hA4, 1003, 8'h01, 1, 0};
    vecs[7] = '{8'hA5, 8'hFE, 8'h5B, 1992, 8'hFE, 1, 0};

    rst_n = 1'b0;
    rx = 1'b1;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (200) tick();
    check("rst_duty", 64'(duty_cycle), 64'd1000);
    check("rst_pos", 64'(last_pos), 64'd0);
    check("rst_dv", 64'(dv_cnt), 64'd0);
    check("rst_fe", 64'(fe_cnt), 64'd0);

    for (int i = 0; i < 8; i++) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      repeat (30) tick();
      check($sformatf("v%0d_duty", i), 64'(duty_cycle), 64'(vecs[i].duty));
      check($sformatf("v%0d_pos", i), 64'(last_pos), 64'(vecs[i].pos));
      check($sformatf("v%0d_dv", i), 64'(dv_cnt - dv0), 64'(vecs[i].dv));
      check($sformatf("v%0d_fe", i), 64'(fe_cnt - fe0), 64'(vecs[i].fe));
      if (vecs[i].dv == 1)
        check($sformatf("v%0d_lat", i),
              64'((dv_cyc - last_start) >= 90 && (dv_cyc - last_start) <= 100),
              64'd1);
    end

    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1);
    repeat (600) tick();
    send_byte(8'h80, 1'b1);
    send_byte(8'h25, 1'b1);
    repeat (30) tick();
    check("to_fe", 64'(fe_cnt - fe0), 64'd1);
    check("to_dv", 64'(dv_cnt - dv0), 64'd0);
    check("to_duty", 64'(duty_cycle), 64'd1992);
    dv0 = dv_cnt;
    send_frame(8'hA5, 8'h80, 8'h25);
    repeat (30) tick();
    check("to_after_duty", 64'(duty_cycle), 64'd1500);
    check("to_after_dv", 64'(dv_cnt - dv0), 64'd1);

    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_fe", 64'(fe_cnt - fe0), 64'd0);
    check("glitch_dv", 64'(dv_cnt - dv0), 64'd0);

    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hA5, 8'h40, 8'hE5);
    repeat (30) tick();
    check("se_first", 64'(duty_cycle), 64'd1250);
    send_byte(8'h33, 1'b0);
    repeat (20) tick();
    send_frame(8'hA5, 8'h80, 8'h25);
    repeat (30) tick();
    check("se_fe", 64'(fe_cnt - fe0), 64'd1);
    check("se_dv", 64'(dv_cnt - dv0), 64'd2);
    check("se_duty", 64'(duty_cycle), 64'd1500);
    check("se_pos", 64'(last_pos), 64'h80);

    send_byte(8'hA5, 1'b1);
    pb = 8'hC0;
    rx = 1'b0;
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      repeat (10) tick();
    end
    rst_n = 1'b0;
    #1;
    check("mid_rst_duty", 64'(duty_cycle), 64'd1000);
    check("mid_rst_pos", 64'(last_pos), 64'd0);
    check("mid_rst_dv", 64'(duty_valid), 64'd0);
    check("mid_rst_fe", 64'(frame_err), 64'd0);
    rx = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (50) tick();
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'hA5, 8'hC0, 8'h65);
    repeat (30) tick();
    check("post_rst_duty", 64'(duty_cycle), 64'd1750);
    check("post_rst_pos", 64'(last_pos), 64'hC0);
    check("post_rst_dv", 64'(dv_cnt - dv0), 64'd1);
    check("post_rst_fe", 64'(fe_cnt - fe0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
